tt_um_priority_decoder: RTL and testbench
=========================================

// Module: tt_um_priority_decoder
// PURPOSE
//   Inverse of the 16-input priority encoder: accepts an 8-bit encoder code
//   (0x00-0x0F = index, 0xF0 = none) on a strobe and rebuilds a 16-bit mask.
//   The mask holds one-hot (replace) or accumulated (OR) bits.
//   Read-back is one byte at a time, plus status flags and an ack toggle.
//   Top-level tile; the strobe/control pins are async, so a 2-flop sync is used.
// PARAMETERS
//   NONE_CODE  8'hF0  code meaning "no input active"
//   SYNC_STAGES 2     synchroniser depth on uio_in[3:0] (>=2)
// PORTS
//   clk      in   1  clock; all state on rising edge
//   rst_n    in   1  synchronous, active-low reset
//   ena      in   1  always 1 when powered; ignored
//   ui_in    in   8  code byte (encoder format)
//   uio_in   in   8  [0] load strobe, [1] byte_sel, [2] clear, [3] accum mode; [7:4] unused
//   uo_out   out  8  registered mask byte: byte_sel ? mask[15:8] : mask[7:0]
//   uio_out  out  8  [7] ack toggle, [6] multi, [5] err, [4] any; [3:0] = 0
//   uio_oe   out  8  constant 8'hF0
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): mask=0, err=0, ack=0, sync/edge flops=0,
//     uo_out=0, uio_out=0. Reset wins over all other inputs.
//   Sync: uio_in[0], [2] and [3] each pass SYNC_STAGES flops. A third flop on
//     the strobe gives edge detect: ld = s_last & ~s_prev.
//   Strobe held high through reset release counts as one rising edge.
//   Timing, with E0 = first edge sampling strobe=1 after 0:
//     ui_in is captured and the mask updated at E(SYNC_STAGES), i.e. E2.
//     uo_out/uio_out reflect it at E3.
//     ui_in must be stable from E0 until E2 inclusive.
//   Decode on ld, with code = ui_in:
//     code[7:4]==0, replace mode (acc=0): mask = 16'h1 << code[3:0].
//     code[7:4]==0, accum mode (acc=1): mask = mask | (1 << code[3:0]).
//     code==NONE_CODE: replace mode -> mask=0; accum mode -> mask unchanged.
//     Any other code is illegal: mask unchanged, err set (sticky).
//     ack toggles on every ld, whether the code is legal or illegal.
//   Clear: while synced clear=1, at each edge mask=0 and err=0; ld is ignored.
//     ack does not toggle for a ld ignored this way.
//   Flags (registered with uo_out):
//     any = |mask.
//     multi = more than one bit set in mask.
//     err = sticky illegal-code flag.
//   byte_sel is not synchronised (quasi-static); uo_out follows it one edge later.
//   Strobe held high: exactly one ld per rising edge; no repeat.
//   Strobe pulses shorter than one clk period may be missed; the ack toggle
//     lets the sender confirm capture.
//   Widths: shift index is 4 bits, so no out-of-range shift is possible.
// TESTING
//   1 Reset: rst_n=0 for 2 clk, then 1 -> uo_out=0x00, uio_out=0x00, uio_oe=0xF0.
//   2 Replace mode, code 0x0B, strobe 0->1, byte_sel=1:
//     uo_out=0x08 at E3, then any=1, multi=0, ack=1.
//     Next, code 0x03 with byte_sel=0 -> uo_out=0x08, byte_sel=1 -> 0x00.
//   3 Accum mode, loads 0x00, 0x07, 0x0F:
//     byte_sel=0 gives 0x81, byte_sel=1 gives 0x80; multi=1; ack=1 after 3 toggles.
//     Then code 0xF0 -> mask unchanged.
//   4 Illegal code 0x25 -> err=1, mask unchanged, ack toggles.
//     Then clear=1 for 3 clk -> mask=0, err=0, any=0.
//   5 Strobe held high 20 clk -> exactly one ack toggle.
//     Strobe high across rst_n release -> one load after reset.
//   6 Clear=1 together with a strobe edge -> mask=0, no ack toggle.
//     Sweep all 16 legal codes in replace mode -> each bit set alone, multi=0.

Source files
------------

// File: rtl/tt_um_priority_decoder.sv
// tt_um_priority_decoder: rebuilds a 16-bit mask from priority-encoder codes loaded on a synchronised strobe
module tt_um_priority_decoder #(
  parameter logic [7:0] NONE_CODE = 8'hF0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [SYNC_STAGES-1:0] s_sync, c_sync, a_sync;
  logic s_prev, ld, clr, acc, ack, err, legal, none;
  logic [15:0] mask, mask_nx, onehot;
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};
  assign uio_oe = 8'hF0;
  always_comb begin
    ld = s_sync[SYNC_STAGES-1] & ~s_prev;
    clr = c_sync[SYNC_STAGES-1];
    acc = a_sync[SYNC_STAGES-1];
    onehot = 16'h1 << ui_in[3:0];
    legal = ui_in[7:4] == 4'h0;
    none = ui_in == NONE_CODE;
    mask_nx = legal ? (acc ? (mask | onehot) : onehot) : (none && !acc) ? 16'h0 : mask;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_sync <= '0;
      c_sync <= '0;
      a_sync <= '0;
      s_prev <= 1'b0;
      mask <= 16'h0;
      err <= 1'b0;
      ack <= 1'b0;
      uo_out <= 8'h0;
      uio_out <= 8'h0;
    end else begin
      s_sync <= {s_sync[SYNC_STAGES-2:0], uio_in[0]};
      c_sync <= {c_sync[SYNC_STAGES-2:0], uio_in[2]};
      a_sync <= {a_sync[SYNC_STAGES-2:0], uio_in[3]};
      s_prev <= s_sync[SYNC_STAGES-1];
      // clear takes precedence and swallows any coincident load, including its ack
      if (clr) begin
        mask <= 16'h0;
        err <= 1'b0;
      end else if (ld) begin
        mask <= mask_nx;
        err <= err | ~(legal | none);
        ack <= ~ack;
      end
      uo_out <= uio_in[1] ? mask[15:8] : mask[7:0];
      uio_out <= {ack, |(mask & (mask - 16'd1)), err, |mask, 4'h0};
    end
  end
endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// tb_tt_um_priority_decoder: directed stimulus with a cycle-stamped expectation queue checked by a monitor
module tb_tt_um_priority_decoder;
  typedef struct {
    int due;
    logic [7:0] uo;
    logic [7:0] uio;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit eack;
  exp_t q[$];
  exp_t mon_e;
  tt_um_priority_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      tests++;
      if (uo_out !== mon_e.uo || uio_out !== mon_e.uio || uio_oe !== 8'hF0) begin
        fails++;
        $display("FAIL %s: got uo=%h uio=%h oe=%h, expected uo=%h uio=%h oe=f0",
                 mon_e.name, uo_out, uio_out, uio_oe, mon_e.uo, mon_e.uio);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  task automatic push(input string n, input logic [7:0] u, input logic [7:0] io, input int d);
    exp_t e;
    e.due = cyc + d;
    e.uo = u;
    e.uio = io;
    e.name = n;
    q.push_back(e);
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] code, input logic bsel, input logic [7:0] u,
                      input logic [7:0] io, input string n);
    ui_in = code;
    uio_in[1] = bsel;
    uio_in[0] = 1'b1;
    push(n, u, io, 4);
    settle(4);
    uio_in[0] = 1'b0;
    settle(3);
  endtask
  task automatic rd(input logic bsel, input logic [7:0] u, input logic [7:0] io, input string n);
    uio_in[1] = bsel;
    push(n, u, io, 1);
    settle(2);
  endtask
  task automatic clear_pulse(input int n);
    uio_in[2] = 1'b1;
    settle(n);
    uio_in[2] = 1'b0;
    settle(4);
  endtask
  task automatic set_acc(input logic a);
    uio_in[3] = a;
    settle(3);
  endtask
  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    settle(2);
    rst_n = 1'b1;
    push("reset", 8'h00, 8'h00, 1);
    settle(3);
    // replace mode
    load(8'h0B, 1'b1, 8'h08, 8'h90, "replace_0b_hi");
    load(8'h03, 1'b0, 8'h08, 8'h10, "replace_03_lo");
    rd(1'b1, 8'h00, 8'h10, "replace_03_hi");
    // accumulate mode from an empty mask
    clear_pulse(3);
    set_acc(1'b1);
    load(8'h00, 1'b0, 8'h01, 8'h90, "acc_00");
    load(8'h07, 1'b0, 8'h81, 8'h50, "acc_07");
    load(8'h0F, 1'b0, 8'h81, 8'hD0, "acc_0f_lo");
    rd(1'b1, 8'h80, 8'hD0, "acc_0f_hi");
    load(8'hF0, 1'b1, 8'h80, 8'h50, "acc_none_keeps");
    // illegal code then clear
    load(8'h25, 1'b0, 8'h81, 8'hF0, "illegal_25");
    clear_pulse(3);
    push("clear_after_err", 8'h00, 8'h80, 1);
    settle(2);
    set_acc(1'b0);
    // strobe held high: one load only
    ui_in = 8'h05;
    uio_in[1] = 1'b0;
    uio_in[0] = 1'b1;
    push("held_first", 8'h20, 8'h10, 4);
    settle(20);
    push("held_no_repeat", 8'h20, 8'h10, 1);
    settle(1);
    uio_in[0] = 1'b0;
    settle(3);
    // strobe high across reset release
    rst_n = 1'b0;
    ui_in = 8'h0A;
    uio_in[1] = 1'b1;
    uio_in[0] = 1'b1;
    push("in_reset", 8'h00, 8'h00, 1);
    settle(2);
    rst_n = 1'b1;
    push("reset_strobe_load", 8'h04, 8'h90, 4);
    settle(4);
    push("reset_strobe_once", 8'h04, 8'h90, 10);
    settle(10);
    uio_in[0] = 1'b0;
    settle(3);
    // clear coincident with a strobe edge
    ui_in = 8'h02;
    uio_in[2] = 1'b1;
    uio_in[0] = 1'b1;
    push("clear_beats_load", 8'h00, 8'h80, 6);
    settle(6);
    uio_in[0] = 1'b0;
    uio_in[2] = 1'b0;
    settle(4);
    // sweep all legal codes in replace mode
    eack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] u;
      eack = ~eack;
      u = 8'h01 << (i % 8);
      load(8'(i), i >= 8, u, {eack, 7'h10}, $sformatf("sweep_%0d", i));
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) settle(1);
    if (q.size() > 0) begin
      fails += q.size();
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
